// File: rtl/pipe_pkg.sv
// Shared pipeline types for the dual-pipe hazard scoreboard.
package pipe_pkg;

  localparam int unsigned NREG = 8;
  localparam int unsigned RW   = $clog2(NREG);

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    LOAD_USE = 2'b01,
    FLAG     = 2'b10,
    WAW      = 2'b11
  } stall_cause_t;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } sb_state_t;

  // One-hot register select over the tracked registers; r0 never tracked.
  function automatic logic [NREG-1:1] reg_bit(input logic [RW-1:0] r, input logic en);
    logic [NREG-1:1] v;
    v = '0;
    if (en && (r != '0)) v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sb_stage_track.sv
// Per-register EX/MEM/WB pending-write shift cell with an EX load marker.
module sb_stage_track (
  input  logic clk,
  input  logic reset_n,
  input  logic set_ex,
  input  logic set_ld,
  output logic busy,
  output logic ld_ex
);

  logic ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, ld_q, ld_d;

  always_comb begin
    ex_d  = set_ex;
    ld_d  = set_ld;
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= 1'b0;
      mem_q <= 1'b0;
      wb_q  <= 1'b0;
      ld_q  <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      ld_q  <= ld_d;
    end
  end

  assign busy  = ex_q | mem_q | wb_q;
  assign ld_ex = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-side hazard scoreboard for the ALU/load-store pipes: stalls, bubbles, busy mask, watchdog.
// Define HAZARD_SCOREBOARD_PERF_CNT_EN to add the stall_cycles counter and perf_clr input.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_STALL = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_src_a_1,
  input  logic [RW-1:0]   id_src_b_1,
  input  logic [RW-1:0]   id_dst_1,
  input  logic            id_wr_1,
  input  logic [RW-1:0]   id_src_a_2,
  input  logic [RW-1:0]   id_src_b_2,
  input  logic [RW-1:0]   id_src_c_2,
  input  logic [RW-1:0]   id_dst_2,
  input  logic            id_wr_2,
  input  logic            id_load_2,
  input  logic            id_uses_flag,
  input  logic            id_sets_flag_2,
  input  logic            flush,
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
  input  logic            perf_clr,
  output logic [15:0]     stall_cycles,
`endif
  output logic            stall,
  output logic            bubble,
  output logic [NREG-1:0] busy_mask,
  output logic [1:0]      stall_cause,
  output logic            wd_err
);

  localparam int unsigned CW = $clog2(MAX_STALL + 1);

  logic [NREG-1:1] busy, ld_ex, set_ex, set_ld;
  logic            fl_ex_q, fl_ex_d;
  sb_state_t       state_q, state_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;
  logic            gate, issue, load_use, flag_hz, waw;
  stall_cause_t    cause;

  function automatic logic src_hit(input logic [RW-1:0] src, input logic [NREG-1:1] ld);
    return (src != '0) && ld[src];
  endfunction

  for (genvar r = 1; r < NREG; r++) begin : g_track
    sb_stage_track u_track (
      .clk     (clk),
      .reset_n (reset_n),
      .set_ex  (set_ex[r]),
      .set_ld  (set_ld[r]),
      .busy    (busy[r]),
      .ld_ex   (ld_ex[r])
    );
  end

  // Hazard detection; a flushed bundle never stalls. WAW is already resolved while in SPLIT.
  always_comb begin
    gate     = id_valid & ~flush;
    load_use = gate & (src_hit(id_src_a_1, ld_ex) | src_hit(id_src_b_1, ld_ex) |
                       src_hit(id_src_a_2, ld_ex) | src_hit(id_src_b_2, ld_ex) |
                       src_hit(id_src_c_2, ld_ex));
    flag_hz  = gate & id_uses_flag & fl_ex_q;
    waw      = gate & (state_q == RUN) & id_wr_1 & id_wr_2 &
               (id_dst_1 == id_dst_2) & (id_dst_1 != '0);
    stall    = load_use | flag_hz | waw;
    bubble   = stall | flush;
    issue    = gate & ~stall;
    if (load_use)     cause = LOAD_USE;
    else if (flag_hz) cause = FLAG;
    else if (waw)     cause = WAW;
    else              cause = NONE;
    stall_cause = cause;
  end

  // Scoreboard writes and split-issue sequencing.
  always_comb begin
    state_d = state_q;
    set_ex  = '0;
    set_ld  = '0;
    fl_ex_d = 1'b0;
    case (state_q)
      RUN: begin
        if (issue) begin
          set_ex  = reg_bit(id_dst_1, id_wr_1) | reg_bit(id_dst_2, id_wr_2);
          set_ld  = reg_bit(id_dst_2, id_wr_2 & id_load_2);
          fl_ex_d = id_sets_flag_2;
        end else if (cause == WAW) begin
          // Pipe 1 leaves in the bubble slot; pipe 2 follows alone next cycle.
          set_ex  = reg_bit(id_dst_1, 1'b1);
          state_d = SPLIT;
        end
      end
      SPLIT: begin
        state_d = RUN;
        if (issue) begin
          set_ex  = reg_bit(id_dst_2, id_wr_2);
          set_ld  = reg_bit(id_dst_2, id_wr_2 & id_load_2);
          fl_ex_d = id_sets_flag_2;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wd_cnt_d = '0;
    if (stall) wd_cnt_d = (wd_cnt_q == CW'(MAX_STALL)) ? wd_cnt_q : wd_cnt_q + CW'(1);
    wd_err_d = wd_err_q | (wd_cnt_d == CW'(MAX_STALL));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      fl_ex_q  <= 1'b0;
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fl_ex_q  <= fl_ex_d;
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign busy_mask = {busy, 1'b0};
  assign wd_err    = wd_err_q;

`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (perf_clr)                  perf_d = '0;
    else if (stall && perf_q != '1) perf_d = perf_q + 16'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against an in-flight-write queue model.
module tb_hazard_scoreboard;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            id_valid, id_wr_1, id_wr_2, id_load_2, id_uses_flag, id_sets_flag_2, flush;
  logic [RW-1:0]   id_src_a_1, id_src_b_1, id_dst_1, id_src_a_2, id_src_b_2, id_src_c_2, id_dst_2;
  logic            stall, bubble, wd_err, stall_w, bubble_w, wd_err_w;
  logic [NREG-1:0] busy_mask, busy_w;
  logic [1:0]      stall_cause, cause_w;
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
  logic [15:0]     stall_cycles, stall_cycles_w;
`endif

  hazard_scoreboard #(.MAX_STALL(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_src_a_1(id_src_a_1), .id_src_b_1(id_src_b_1), .id_dst_1(id_dst_1), .id_wr_1(id_wr_1),
    .id_src_a_2(id_src_a_2), .id_src_b_2(id_src_b_2), .id_src_c_2(id_src_c_2),
    .id_dst_2(id_dst_2), .id_wr_2(id_wr_2), .id_load_2(id_load_2),
    .id_uses_flag(id_uses_flag), .id_sets_flag_2(id_sets_flag_2), .flush(flush),
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    .perf_clr(1'b0), .stall_cycles(stall_cycles),
`endif
    .stall(stall), .bubble(bubble), .busy_mask(busy_mask), .stall_cause(stall_cause),
    .wd_err(wd_err)
  );

  // Short-watchdog instance: two back-to-back stalls are reachable, four are not.
  hazard_scoreboard #(.MAX_STALL(2)) u_dut_wd (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_src_a_1(id_src_a_1), .id_src_b_1(id_src_b_1), .id_dst_1(id_dst_1), .id_wr_1(id_wr_1),
    .id_src_a_2(id_src_a_2), .id_src_b_2(id_src_b_2), .id_src_c_2(id_src_c_2),
    .id_dst_2(id_dst_2), .id_wr_2(id_wr_2), .id_load_2(id_load_2),
    .id_uses_flag(id_uses_flag), .id_sets_flag_2(id_sets_flag_2), .flush(flush),
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    .perf_clr(1'b0), .stall_cycles(stall_cycles_w),
`endif
    .stall(stall_w), .bubble(bubble_w), .busy_mask(busy_w), .stall_cause(cause_w),
    .wd_err(wd_err_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: list of pending writes with their age (0=EX, 1=MEM, 2=WB).
  typedef struct {
    int r;
    int age;
    bit ld;
  } wr_t;

  wr_t             inflight[$];
  bit              m_flag, m_split, m_stall, m_bubble;
  int              m_cause;
  bit [NREG-1:0]   m_busy;
  int              cnt4, cnt2;
  bit              err4, err2;

  task automatic m_reset();
    inflight.delete();
    m_flag = 0; m_split = 0; m_stall = 0; m_bubble = 0; m_cause = 0;
    cnt4 = 0; cnt2 = 0; err4 = 0; err2 = 0;
  endtask

  function automatic bit src_hit(input int s);
    if (s == 0) return 0;
    foreach (inflight[i])
      if (inflight[i].age == 0 && inflight[i].ld && inflight[i].r == s) return 1;
    return 0;
  endfunction

  task automatic m_eval();
    bit gate, lu, fh, waw;
    gate = id_valid && !flush;
    lu   = gate && (src_hit(int'(id_src_a_1)) || src_hit(int'(id_src_b_1)) ||
                    src_hit(int'(id_src_a_2)) || src_hit(int'(id_src_b_2)) ||
                    src_hit(int'(id_src_c_2)));
    fh   = gate && id_uses_flag && m_flag;
    waw  = gate && !m_split && id_wr_1 && id_wr_2 && id_dst_1 == id_dst_2 && id_dst_1 != 0;
    m_stall  = lu || fh || waw;
    m_bubble = m_stall || flush;
    m_cause  = lu ? 1 : fh ? 2 : waw ? 3 : 0;
    m_busy   = '0;
    foreach (inflight[i]) m_busy[inflight[i].r] = 1'b1;
  endtask

  function automatic void m_add(input int r, input bit wr, input bit ld);
    wr_t e;
    if (wr && r != 0) begin
      e.r = r; e.age = 0; e.ld = ld;
      inflight.push_back(e);
    end
  endfunction

  task automatic m_step();
    wr_t nq[$];
    bit  issue, new_flag;
    foreach (inflight[i]) begin
      wr_t e = inflight[i];
      e.age++;
      if (e.age <= 2) nq.push_back(e);
    end
    inflight = nq;
    issue    = id_valid && !flush && !m_stall;
    new_flag = 0;
    if (m_split) begin
      if (issue) begin
        m_add(int'(id_dst_2), id_wr_2, id_load_2);
        new_flag = id_sets_flag_2;
      end
      m_split = 0;
    end else if (issue) begin
      m_add(int'(id_dst_1), id_wr_1, 0);
      m_add(int'(id_dst_2), id_wr_2, id_load_2);
      new_flag = id_sets_flag_2;
    end else if (m_cause == 3) begin
      m_add(int'(id_dst_1), 1, 0);
      m_split = 1;
    end
    m_flag = new_flag;
    if (m_stall) begin
      cnt4++; cnt2++;
      if (cnt4 >= 4) err4 = 1;
      if (cnt2 >= 2) err2 = 1;
    end else begin
      cnt4 = 0; cnt2 = 0;
    end
  endtask

  // Caller drives inputs after a falling edge; this checks and advances one clock.
  task automatic run_cycle();
    #1;
    m_eval();
    check("stall",     stall,        m_stall);
    check("bubble",    bubble,       m_bubble);
    check("cause",     stall_cause,  m_cause);
    check("busy_mask", busy_mask,    m_busy);
    check("wd_err",    wd_err,       err4);
    check("stall_w",   stall_w,      m_stall);
    check("wd_err_w",  wd_err_w,     err2);
    @(posedge clk);
    m_step();
  endtask

  task automatic idle_bundle();
    id_valid = 0; id_wr_1 = 0; id_wr_2 = 0; id_load_2 = 0;
    id_uses_flag = 0; id_sets_flag_2 = 0; flush = 0;
    id_src_a_1 = '0; id_src_b_1 = '0; id_dst_1 = '0;
    id_src_a_2 = '0; id_src_b_2 = '0; id_src_c_2 = '0; id_dst_2 = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_bundle(); run_cycle();
    end
  endtask

  task automatic load_into(input int r, input bit sets_flag);
    @(negedge clk); idle_bundle();
    id_valid = 1; id_wr_2 = 1; id_load_2 = 1; id_dst_2 = RW'(r); id_sets_flag_2 = sets_flag;
    run_cycle();
  endtask

  task automatic rand_bundle();
    id_valid       = ($urandom_range(0, 99) < 85);
    id_src_a_1     = RW'($urandom_range(0, NREG - 1));
    id_src_b_1     = RW'($urandom_range(0, NREG - 1));
    id_dst_1       = RW'($urandom_range(0, NREG - 1));
    id_src_a_2     = RW'($urandom_range(0, NREG - 1));
    id_src_b_2     = RW'($urandom_range(0, NREG - 1));
    id_src_c_2     = RW'($urandom_range(0, NREG - 1));
    id_dst_2       = RW'($urandom_range(0, NREG - 1));
    id_wr_1        = 1'($urandom_range(0, 1));
    id_wr_2        = 1'($urandom_range(0, 1));
    id_load_2      = 1'($urandom_range(0, 1));
    id_uses_flag   = ($urandom_range(0, 9) < 3);
    id_sets_flag_2 = ($urandom_range(0, 9) < 3);
  endtask

  initial begin
    bit exp5 [6] = '{0, 1, 1, 1, 1, 0};

    idle_bundle();
    m_reset();
    reset_n = 0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_bubble", bubble, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_cause", stall_cause, 0);
    check("rst_wd", wd_err, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;

    // Load-use on r3: one stall cycle, then the same bundle issues.
    load_into(3, 0);
    @(negedge clk); idle_bundle(); id_valid = 1; id_src_a_1 = 3;
    #1;
    check("lu_stall", stall, 1);
    check("lu_cause", stall_cause, 2'b01);
    run_cycle();
    @(negedge clk);
    #1;
    check("lu_release", stall, 0);
    run_cycle();
    drain();

    // Load to r0 is untracked.
    load_into(0, 0);
    @(negedge clk); idle_bundle(); id_valid = 1; id_src_a_1 = 0;
    #1;
    check("r0_stall", stall, 0);
    check("r0_busy", busy_mask, 0);
    run_cycle();
    drain();

    // Same-bundle WAW on r5: stall, split, then r5 busy for four cycles.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle_bundle();
      if (c < 2) begin
        id_valid = 1; id_wr_1 = 1; id_wr_2 = 1; id_dst_1 = 5; id_dst_2 = 5;
      end
      #1;
      check("waw_busy5", busy_mask[5], exp5[c]);
      if (c == 0) check("waw_cause", stall_cause, 2'b11);
      if (c == 1) check("split_stall", stall, 0);
      run_cycle();
    end
    drain();

    // Flag hazard masked by a simultaneous flush.
    load_into(2, 1);
    @(negedge clk); idle_bundle(); id_valid = 1; id_uses_flag = 1; flush = 1; id_wr_1 = 1; id_dst_1 = 6;
    #1;
    check("flush_stall", stall, 0);
    check("flush_bubble", bubble, 1);
    check("flush_cause", stall_cause, 0);
    run_cycle();
    @(negedge clk); idle_bundle();
    #1;
    check("flush_noissue", busy_mask[6], 0);
    run_cycle();
    drain();

    // Load-use then WAW on the held bundle: two consecutive stalls trip the short watchdog.
    load_into(4, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle_bundle();
      id_valid = 1; id_src_a_1 = 4; id_wr_1 = 1; id_wr_2 = 1; id_dst_1 = 6; id_dst_2 = 6;
      run_cycle();
    end
    #1;
    check("wd_short_set", wd_err_w, 1);
    check("wd_long_clear", wd_err, 0);
    drain();

    // Asynchronous reset in the middle of a load-use stall.
    load_into(3, 0);
    @(negedge clk); idle_bundle(); id_valid = 1; id_src_a_1 = 3;
    #1;
    check("pre_rst_stall", stall, 1);
    check("pre_rst_wd", wd_err_w, 1);
    reset_n = 0;
    #1;
    check("arst_stall", stall, 0);
    check("arst_bubble", bubble, 0);
    check("arst_busy", busy_mask, 0);
    check("arst_cause", stall_cause, 0);
    check("arst_wd", wd_err_w, 0);
    m_reset();
    @(negedge clk);
    idle_bundle();
    reset_n = 1;

    // Random traffic; a stalled bundle is held, as IF/ID would hold it.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!m_stall) rand_bundle();
      flush = ($urandom_range(0, 9) == 0);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
